// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with start/done handshake.
// Round-to-nearest-even, subnormals flushed to zero, IEEE special values handled.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         done,
  output logic         busy,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_inexact
);

  localparam int SW  = MAN_W + 4;           // hidden + fraction + guard + round + sticky
  localparam int EW2 = EXP_W + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W:0]     ma_q, ma_d, mb_q, mb_d;
  logic               spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [W-1:0]       spec_res_q, spec_res_d;
  logic               sign_q, sign_d, eff_sub_q, eff_sub_d, zero_q, zero_d;
  logic [EW2-1:0]     exp_q, exp_d;
  logic [SW-1:0]      big_q, big_d, small_q, small_d, mant_q, mant_d;
  logic [SW:0]        sum_q, sum_d;
  logic [W-1:0]       res_q, res_d, r_q, r_d;
  logic               res_inv_q, res_inv_d, res_ovf_q, res_ovf_d, res_inx_q, res_inx_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic               inv_q, inv_d, ovf_q, ovf_d, inx_q, inx_d;

  logic [EXP_W-1:0]   ea_w, eb_w, diff, e_big, e_small;
  logic [MAN_W-1:0]   fa_w, fb_w, frac;
  logic [MAN_W:0]     m_big, m_small;
  logic [MAN_W+2:0]   small_ext;
  logic [MAN_W+1:0]   rounded;
  logic [EW2-1:0]     exp_r;
  logic [LZW-1:0]     lz;
  logic               nan_a, nan_b, inf_a, inf_b, sb_w, a_big, up, rs;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default up front so no latch can be inferred.
    state_d = state_q;  op_d = op_q;  a_d = a_q;  b_d = b_q;
    sa_d = sa_q;  sb_d = sb_q;  ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
    spec_d = spec_q;  spec_inv_d = spec_inv_q;  spec_res_d = spec_res_q;
    sign_d = sign_q;  eff_sub_d = eff_sub_q;  zero_d = zero_q;  exp_d = exp_q;
    big_d = big_q;  small_d = small_q;  mant_d = mant_q;  sum_d = sum_q;
    res_d = res_q;  res_inv_d = res_inv_q;  res_ovf_d = res_ovf_q;  res_inx_d = res_inx_q;
    r_d = r_q;  done_d = 1'b0;  busy_d = busy_q;
    inv_d = inv_q;  ovf_d = ovf_q;  inx_d = inx_q;
    ea_w = a_q[W-2:MAN_W];  eb_w = b_q[W-2:MAN_W];
    fa_w = a_q[MAN_W-1:0];  fb_w = b_q[MAN_W-1:0];
    nan_a = 1'b0;  nan_b = 1'b0;  inf_a = 1'b0;  inf_b = 1'b0;  sb_w = 1'b0;
    a_big = 1'b0;  diff = '0;  e_big = '0;  e_small = '0;  m_big = '0;  m_small = '0;
    small_ext = '0;  lz = '0;  up = 1'b0;  rs = 1'b0;  rounded = '0;  exp_r = '0;  frac = '0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // The IDLE cycle that carries the done pulse still counts as the DONE cycle.
        if (start && !done_q) begin
          a_d = a;  b_d = b;  op_d = op;
          busy_d = 1'b1;
          inv_d = 1'b0;  ovf_d = 1'b0;  inx_d = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sb_w  = b_q[W-1] ^ op_q;
        nan_a = (ea_w == EXP_MAX) && (fa_w != '0);
        nan_b = (eb_w == EXP_MAX) && (fb_w != '0);
        inf_a = (ea_w == EXP_MAX) && (fa_w == '0);
        inf_b = (eb_w == EXP_MAX) && (fb_w == '0);
        sa_d  = a_q[W-1];
        sb_d  = sb_w;
        ea_d  = ea_w;
        eb_d  = eb_w;
        ma_d  = (ea_w == '0) ? '0 : {1'b1, fa_w};
        mb_d  = (eb_w == '0) ? '0 : {1'b1, fb_w};
        spec_d = nan_a | nan_b | inf_a | inf_b;
        spec_inv_d = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (a_q[W-1] != sb_w))) begin
          spec_res_d = QNAN;
          spec_inv_d = 1'b1;
        end else if (inf_a) spec_res_d = {a_q[W-1], EXP_MAX, {MAN_W{1'b0}}};
        else                spec_res_d = {sb_w, EXP_MAX, {MAN_W{1'b0}}};
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
        e_big   = a_big ? ea_q : eb_q;
        e_small = a_big ? eb_q : ea_q;
        m_big   = a_big ? ma_q : mb_q;
        m_small = a_big ? mb_q : ma_q;
        diff    = e_big - e_small;
        small_ext = {m_small, 2'b00};
        if (32'(diff) >= 32'(MAN_W + 3)) begin
          small_d = {{(SW-1){1'b0}}, |m_small};
        end else begin
          small_d = {small_ext >> diff,
                     |(small_ext & ~({(MAN_W+3){1'b1}} << diff))};
        end
        big_d     = {m_big, 3'b000};
        exp_d     = {2'b00, e_big};
        sign_d    = a_big ? sa_q : sb_q;
        eff_sub_d = sa_q ^ sb_q;
        state_d   = S_ADD;
      end
      S_ADD: begin
        // big holds the larger magnitude, so the difference never goes negative.
        sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                            : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        zero_d = 1'b0;
        lz     = lzc(sum_q[SW-1:0]);
        if (sum_q == '0) begin
          zero_d = 1'b1;
          sign_d = eff_sub_q ? 1'b0 : sign_q;
        end else if (sum_q[SW]) begin
          mant_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + EW2'(1);
        end else if (32'(exp_q) <= 32'(lz)) begin
          zero_d = 1'b1;
        end else begin
          mant_d = sum_q[SW-1:0] << lz;
          exp_d  = exp_q - EW2'(lz);
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        res_inv_d = 1'b0;  res_ovf_d = 1'b0;  res_inx_d = 1'b0;
        rs      = mant_q[1] | mant_q[0];
        up      = mant_q[2] & (rs | mant_q[3]);
        rounded = {1'b0, mant_q[SW-1:3]} + (MAN_W+2)'(up);
        exp_r   = rounded[MAN_W+1] ? exp_q + EW2'(1) : exp_q;
        frac    = rounded[MAN_W+1] ? '0 : rounded[MAN_W-1:0];
        if (spec_q) begin
          res_d     = spec_res_q;
          res_inv_d = spec_inv_q;
        end else if (zero_q) begin
          res_d = {sign_q, {(W-1){1'b0}}};
        end else if (exp_r >= {2'b00, EXP_MAX}) begin
          res_d     = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
          res_ovf_d = 1'b1;
          res_inx_d = 1'b1;
        end else begin
          res_d     = {sign_q, exp_r[EXP_W-1:0], frac};
          res_inx_d = mant_q[2] | rs;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        r_d = res_q;
        inv_d = res_inv_q;  ovf_d = res_ovf_q;  inx_d = res_inx_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, datapath included, is reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  op_q <= 1'b0;  a_q <= '0;  b_q <= '0;
      sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
      spec_q <= 1'b0;  spec_inv_q <= 1'b0;  spec_res_q <= '0;
      sign_q <= 1'b0;  eff_sub_q <= 1'b0;  zero_q <= 1'b0;  exp_q <= '0;
      big_q <= '0;  small_q <= '0;  mant_q <= '0;  sum_q <= '0;
      res_q <= '0;  res_inv_q <= 1'b0;  res_ovf_q <= 1'b0;  res_inx_q <= 1'b0;
      r_q <= '0;  done_q <= 1'b0;  busy_q <= 1'b0;
      inv_q <= 1'b0;  ovf_q <= 1'b0;  inx_q <= 1'b0;
    end else begin
      state_q <= state_d;  op_q <= op_d;  a_q <= a_d;  b_q <= b_d;
      sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
      spec_q <= spec_d;  spec_inv_q <= spec_inv_d;  spec_res_q <= spec_res_d;
      sign_q <= sign_d;  eff_sub_q <= eff_sub_d;  zero_q <= zero_d;  exp_q <= exp_d;
      big_q <= big_d;  small_q <= small_d;  mant_q <= mant_d;  sum_q <= sum_d;
      res_q <= res_d;  res_inv_q <= res_inv_d;  res_ovf_q <= res_ovf_d;  res_inx_q <= res_inx_d;
      r_q <= r_d;  done_q <= done_d;  busy_q <= busy_d;
      inv_q <= inv_d;  ovf_q <= ovf_d;  inx_q <= inx_d;
    end
  end

  assign r             = r_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign flag_invalid  = inv_q;
  assign flag_overflow = ovf_q;
  assign flag_inexact  = inx_q;

endmodule
